// File: rtl/razzle_pkg.sv
// Shared types, screen constants and the per-axis
// position update for the bouncing square.
package razzle_pkg;

  localparam int H_PIX     = 640;
  localparam int V_PIX     = 480;
  localparam int X_MAX_DEF = 511;
  localparam int Y_MAX_DEF = 479;

  typedef enum logic [1:0] {
    WAIT,
    MOVE_X,
    MOVE_Y,
    COMMIT
  } state_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  typedef struct packed {
    logic [9:0] pos;
    dir_t       dir;
    logic       rev;
  } axis_t;

  // One axis step; all arithmetic at 10 bits.
  // Landing exactly on a wall keeps direction.
  function automatic axis_t axis_upd(
    input logic [9:0] pos,
    input dir_t       dir,
    input logic [3:0] step,
    input logic [9:0] size,
    input logic [9:0] lim
  );
    axis_t      r;
    logic [9:0] stp;
    stp   = {6'd0, step};
    r.pos = pos;
    r.dir = dir;
    r.rev = 1'b0;
    if (dir == DIR_POS) begin
      if (pos + size - 10'd1 + stp > lim) begin
        r.pos = lim - size + 10'd1;
        r.dir = DIR_NEG;
        r.rev = 1'b1;
      end else begin
        r.pos = pos + stp;
      end
    end else begin
      if (pos < stp) begin
        r.pos = 10'd0;
        r.dir = DIR_POS;
        r.rev = 1'b1;
      end else begin
        r.pos = pos - stp;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Synchronises VGA_VS and flags its falling edge.
// fall is combinational; frame_tick is its registered copy.
module vs_edge_sync (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic VGA_VS,
  output logic fall,
  output logic frame_tick
);

  logic s1;
  logic s2;
  logic s2_q;

  assign fall = s2_q & ~s2;

  // Two-flop sync, edge history and pulse register.
  // Flops reset high so no edge appears after reset.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      s1         <= 1'b1;
      s2         <= 1'b1;
      s2_q       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      s1         <= VGA_VS;
      s2         <= s1;
      s2_q       <= s2;
      frame_tick <= fall;
    end
  end

endmodule

// File: rtl/square_bouncer.sv
// Moves a square one step per frame and bounces it
// off the screen edges; outputs update atomically.
module square_bouncer
  import razzle_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       VGA_VS,
  input  logic       Run,
  input  logic [3:0] Step,
  output logic [8:0] x1,
  output logic [8:0] x2,
  output logic [8:0] y1,
  output logic [8:0] y2,
  output logic       frame_tick,
  output logic       bounce,
  output logic [7:0] frame_count
);

  localparam logic [9:0] SZ = 10'(SIZE);
  localparam logic [9:0] XM = 10'(X_MAX);
  localparam logic [9:0] YM = 10'(Y_MAX);
  localparam logic [8:0] SZ_M1 = 9'(SIZE - 1);

  state_t     state;
  logic [9:0] xpos;
  logic [9:0] ypos;
  dir_t       dx;
  dir_t       dy;
  logic       bflag;
  logic       fall;
  axis_t      ux;
  axis_t      uy;
  logic [9:0] xe;
  logic [9:0] ye;

  vs_edge_sync u_sync (
    .CLOCK_50  (CLOCK_50),
    .Reset     (Reset),
    .VGA_VS    (VGA_VS),
    .fall      (fall),
    .frame_tick(frame_tick)
  );

  // Candidate next positions for both axes.
  always_comb begin
    ux = axis_upd(xpos, dx, Step, SZ, XM);
    uy = axis_upd(ypos, dy, Step, SZ, YM);
    xe = xpos + SZ - 10'd1;
    ye = ypos + SZ - 10'd1;
  end

  // Frame counter and move FSM; WAIT exits on the
  // same edge that raises frame_tick.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state       <= WAIT;
      xpos        <= 10'd0;
      ypos        <= 10'd0;
      dx          <= DIR_POS;
      dy          <= DIR_POS;
      bflag       <= 1'b0;
      bounce      <= 1'b0;
      frame_count <= 8'd0;
      x1          <= 9'd0;
      x2          <= SZ_M1;
      y1          <= 9'd0;
      y2          <= SZ_M1;
    end else begin
      bounce <= 1'b0;
      if (fall) frame_count <= frame_count + 8'd1;
      unique case (state)
        WAIT: begin
          if (fall && Run) begin
            bflag <= 1'b0;
            state <= MOVE_X;
          end
        end
        MOVE_X: begin
          xpos  <= ux.pos;
          dx    <= ux.dir;
          bflag <= ux.rev;
          state <= MOVE_Y;
        end
        MOVE_Y: begin
          ypos  <= uy.pos;
          dy    <= uy.dir;
          bflag <= bflag | uy.rev;
          state <= COMMIT;
        end
        COMMIT: begin
          x1     <= xpos[8:0];
          x2     <= xe[8:0];
          y1     <= ypos[8:0];
          y2     <= ye[8:0];
          bounce <= bflag;
          state  <= WAIT;
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_square_bouncer.sv
// Directed table of frames with hand-computed positions,
// plus reset, wrap and mid-move reset sequences.
module tb_square_bouncer;

  logic       CLOCK_50;
  logic       Reset;
  logic       VGA_VS;
  logic       Run;
  logic [3:0] Step;
  logic [8:0] x1;
  logic [8:0] x2;
  logic [8:0] y1;
  logic [8:0] y2;
  logic       frame_tick;
  logic       bounce;
  logic [7:0] frame_count;

  int ncmp = 0;
  int nerr = 0;

  square_bouncer dut (
    .CLOCK_50   (CLOCK_50),
    .Reset      (Reset),
    .VGA_VS     (VGA_VS),
    .Run        (Run),
    .Step       (Step),
    .x1         (x1),
    .x2         (x2),
    .y1         (y1),
    .y2         (y2),
    .frame_tick (frame_tick),
    .bounce     (bounce),
    .frame_count(frame_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       run;
    logic [3:0] step;
    int         reps;
    int         ex;
    int         ey;
    int         eb;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input int act,
                     input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_x1"}, int'(x1), 0);
    chk({nm, "_x2"}, int'(x2), 31);
    chk({nm, "_y1"}, int'(y1), 0);
    chk({nm, "_y2"}, int'(y2), 31);
    chk({nm, "_tick"}, int'(frame_tick), 0);
    chk({nm, "_bounce"}, int'(bounce), 0);
    chk({nm, "_fc"}, int'(frame_count), 0);
  endtask

  // One VGA_VS low/high frame; outputs captured at T+3.
  task automatic do_frame(output int nt, output int nb,
                          output logic [8:0] a,
                          output logic [8:0] b,
                          output logic [8:0] c,
                          output logic [8:0] d);
    int t;
    t  = -1;
    nt = 0;
    nb = 0;
    a  = x1;
    b  = x2;
    c  = y1;
    d  = y2;
    VGA_VS = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) VGA_VS = 1'b1;
      @(negedge CLOCK_50);
      if (frame_tick) begin
        nt++;
        if (t < 0) t = i;
      end
      if (bounce) nb++;
      if (t >= 0 && i == t + 3) begin
        a = x1;
        b = x2;
        c = y1;
        d = y2;
      end
    end
  endtask

  initial begin
    int nt;
    int nb;
    int seen;
    int fc_exp;
    int fc_save;
    logic [8:0] a;
    logic [8:0] b;
    logic [8:0] c;
    logic [8:0] d;

    tbl[0]  = '{1'b1, 4'd4,  1,  4,   4,   0};
    tbl[1]  = '{1'b1, 4'd15, 29, 439, 439, 0};
    tbl[2]  = '{1'b1, 4'd7,  1,  446, 446, 0};
    tbl[3]  = '{1'b1, 4'd2,  1,  448, 448, 0};
    tbl[4]  = '{1'b1, 4'd2,  1,  450, 448, 1};
    tbl[5]  = '{1'b1, 4'd14, 1,  464, 434, 0};
    tbl[6]  = '{1'b1, 4'd14, 1,  478, 420, 0};
    tbl[7]  = '{1'b1, 4'd4,  1,  480, 416, 1};
    tbl[8]  = '{1'b1, 4'd4,  1,  476, 412, 0};
    tbl[9]  = '{1'b1, 4'd0,  1,  476, 412, 0};
    tbl[10] = '{1'b1, 4'd15, 1,  461, 397, 0};
    tbl[11] = '{1'b0, 4'd5,  3,  461, 397, 0};

    Reset  = 1'b1;
    VGA_VS = 1'b1;
    Run    = 1'b0;
    Step   = 4'd0;
    repeat (3) @(negedge CLOCK_50);
    Reset = 1'b0;
    chk_rst("reset");
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      if (frame_tick) seen++;
    end
    chk("idle_no_tick", seen, 0);

    fc_exp = 0;
    foreach (tbl[r]) begin
      Run  = tbl[r].run;
      Step = tbl[r].step;
      for (int k = 0; k < tbl[r].reps; k++) begin
        do_frame(nt, nb, a, b, c, d);
        fc_exp = (fc_exp + 1) % 256;
        chk($sformatf("v%0d_ticks", r), nt, 1);
        chk($sformatf("v%0d_fc", r),
            int'(frame_count), fc_exp);
        chk($sformatf("v%0d_bounce", r), nb,
            (k == tbl[r].reps - 1) ? tbl[r].eb : 0);
        if (k == tbl[r].reps - 1) begin
          chk($sformatf("v%0d_x1", r), int'(a), tbl[r].ex);
          chk($sformatf("v%0d_x2", r), int'(b),
              tbl[r].ex + 31);
          chk($sformatf("v%0d_y1", r), int'(c), tbl[r].ey);
          chk($sformatf("v%0d_y2", r), int'(d),
              tbl[r].ey + 31);
        end
      end
    end

    Run     = 1'b0;
    fc_save = fc_exp;
    seen    = 0;
    for (int f = 0; f < 256; f++) begin
      do_frame(nt, nb, a, b, c, d);
      if (nt != 1 || nb != 0) seen++;
    end
    chk("wrap_frames_bad", seen, 0);
    chk("wrap_fc", int'(frame_count), fc_save);
    chk("wrap_x1", int'(x1), 461);
    chk("wrap_y2", int'(y2), 428);

    Run    = 1'b1;
    Step   = 4'd4;
    VGA_VS = 1'b0;
    seen   = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge CLOCK_50);
      if (frame_tick) seen = 1;
    end
    chk("mid_tick_seen", seen, 1);
    @(negedge CLOCK_50);
    Reset  = 1'b1;
    VGA_VS = 1'b1;
    @(negedge CLOCK_50);
    Reset = 1'b0;
    chk_rst("mid_reset");
    nb = 0;
    nt = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK_50);
      if (bounce) nb++;
      if (frame_tick) nt++;
      if (x1 != 9'd0 || y1 != 9'd0) seen++;
    end
    chk("mid_no_bounce", nb, 0);
    chk("mid_no_tick", nt, 0);
    chk("mid_no_update", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/square_bouncer.md
SQUARE_BOUNCER -- requirements
Module: square_bouncer

Interface
REQ-001 SIZE, 32, square edge length in pixels (2..64).
REQ-002 X_MAX, 511, rightmost legal pixel column.
REQ-003 Y_MAX, 479, bottom legal pixel row.
REQ-004 CLOCK_50  input  1  system clock; one clock only; all state on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 VGA_VS  input  1  vertical sync from the VGA timing stage, active low, asynchronous to the logic.
REQ-007 Run  input  1  1 = square moves each frame; 0 = position frozen.
REQ-008 Step  input  4  pixels moved per frame on each axis (0..15).
REQ-009 x1  output  9  left column of the square (inclusive).
REQ-010 x2  output  9  right column, always x1+SIZE-1.
REQ-011 y1  output  9  top row (inclusive).
REQ-012 y2  output  9  bottom row, always y1+SIZE-1.
REQ-013 frame_tick  output  1  one-cycle pulse per detected VGA_VS falling edge.
REQ-014 bounce  output  1  one-cycle pulse when either axis reverses direction.
REQ-015 frame_count  output  8  frames seen since reset, wraps 255->0.

Function
REQ-016 VGA_VS shall pass through a 2-flop synchroniser; a falling edge is 1 on stage 2 in the previous cycle and 0 in the current cycle.
REQ-017 frame_tick shall be registered and high for exactly one cycle (T) per falling edge; frame_count shall increment in the same cycle.
REQ-018 FSM states: WAIT, MOVE_X, MOVE_Y, COMMIT; WAIT->MOVE_X on frame_tick with Run=1; MOVE_X->MOVE_Y->COMMIT->WAIT unconditionally.
REQ-019 frame_tick with Run=0 shall keep the FSM in WAIT; frame_count still increments.
REQ-020 frame_tick outside WAIT shall be ignored by the FSM (frame_count still increments).
REQ-021 Internal xpos/ypos shall be 10 bits; all comparisons shall be at 10 bits with no truncation.
REQ-022 MOVE_X, dx=+: if xpos+SIZE-1+Step > X_MAX then xpos=X_MAX-SIZE+1, dx=-, bounce flag set; else xpos+=Step.
REQ-023 MOVE_X, dx=-: if xpos < Step then xpos=0, dx=+, bounce flag set; else xpos-=Step.
REQ-024 MOVE_Y shall apply REQ-022/023 to ypos, dy and Y_MAX.
REQ-025 Exact wall landing (sum == X_MAX, or xpos == Step) shall not reverse direction.
REQ-026 COMMIT shall load x1,x2,y1,y2 together from xpos/ypos in one cycle; outputs change at T+3 and never partially.
REQ-027 bounce shall pulse one cycle during COMMIT if either axis reversed this frame; simultaneous X and Y reversals give one pulse.
REQ-028 Step=0 shall leave position unchanged, generate no bounce, and still cycle the FSM.
REQ-029 Step and Run shall be sampled in MOVE_X/MOVE_Y and at WAIT exit only.

Reset
REQ-030 Reset high at a clock edge shall, at that edge and from any state, set: state=WAIT, xpos=ypos=0, dx=dy=+, x1=0, x2=SIZE-1, y1=0, y2=SIZE-1, frame_tick=0, bounce=0, frame_count=0, both sync flops=1.
REQ-031 Sync flops resetting to 1 shall guarantee no false frame_tick in the first cycles after reset.
REQ-032 Reset in MOVE_X/MOVE_Y/COMMIT shall discard the pending update; no bounce pulse.

Structure
REQ-033 Package razzle_pkg holds: FSM state enum, direction type, screen constants (640, 480, X_MAX, Y_MAX defaults).
REQ-034 One sub-module, vs_edge_sync: 2-flop synchroniser plus falling-edge pulse generator, reset per REQ-030.
REQ-035 Axis update (REQ-022/023) shall be one shared function in razzle_pkg, used for both axes.

Verification (SIZE=32, defaults)
REQ-036 Reset -> x1=0, x2=31, y1=0, y2=31, frame_tick=0, bounce=0, frame_count=0; no tick for 10 cycles with VGA_VS=1.
REQ-037 Run=1, Step=4, one VGA_VS 1->0 -> frame_tick single pulse; at T+3 x1=4, x2=35, y1=4, y2=35; frame_count=1.
REQ-038 xpos=478, dx=+, Step=4, one frame -> x1=480, x2=511, dx=-, one bounce pulse; next frame x1=476.
REQ-039 ypos=446, dy=+, Step=2 -> y1=448, y2=479, no bounce; next frame y1=448, dy=-, bounce pulse.
REQ-040 Run=0, three frames -> x1..y2 unchanged, frame_count +3; 256 frames -> frame_count wraps to original value.
REQ-041 Reset asserted in MOVE_Y -> next cycle all REQ-030 values, no bounce, no output update.
